// File: rtl/instruction_decode_hz.sv
// instruction_decode_hz -- MIPS ID stage.
//   Register file with same-cycle WB bypass, main decoder, immediate
//   extension, load-use / branch-operand hazard detection, early branch and
//   jump resolution, and the ID/EX pipeline register.
// Ports:
//   clk, i_rst                 clock, async active-high reset
//   i_instruction/i_pcounter4  instruction and its PC+4 from IF/ID
//   i_valid, i_flush           slot-valid and squash
//   i_wb_*                     register-file write port
//   i_ex_*, i_mem_*            downstream destinations for hazard/forwarding
//   o_stall, o_pc_sel,
//   o_pc_target, o_illegal     combinational controls back to IF
//   o_valid .. o_link          registered ID/EX fields for EX
module instruction_decode_hz #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int LINK_REG    = 31
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic [31:0]            i_instruction,
  input  logic [NB_DATA-1:0]     i_pcounter4,
  input  logic                   i_valid,
  input  logic                   i_flush,
  input  logic                   i_wb_we,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0]     i_wb_data,
  input  logic                   i_ex_regWrite,
  input  logic                   i_ex_memRead,
  input  logic [NB_REG_ADDR-1:0] i_ex_wr_addr,
  input  logic                   i_mem_regWrite,
  input  logic                   i_mem_memRead,
  input  logic [NB_REG_ADDR-1:0] i_mem_wr_addr,
  input  logic [NB_DATA-1:0]     i_mem_alu_result,
  output logic                   o_stall,
  output logic                   o_pc_sel,
  output logic [NB_DATA-1:0]     o_pc_target,
  output logic                   o_illegal,
  output logic                   o_valid,
  output logic [NB_REG_ADDR-1:0] o_rs,
  output logic [NB_REG_ADDR-1:0] o_rt,
  output logic [NB_REG_ADDR-1:0] o_wr_addr,
  output logic [NB_DATA-1:0]     o_reg_DA,
  output logic [NB_DATA-1:0]     o_reg_DB,
  output logic [NB_DATA-1:0]     o_immediate,
  output logic [NB_DATA-1:0]     o_pcounter4,
  output logic [5:0]             o_opcode,
  output logic [4:0]             o_shamt,
  output logic [5:0]             o_func,
  output logic                   o_regWrite,
  output logic                   o_mem2Reg,
  output logic                   o_memRead,
  output logic                   o_memWrite,
  output logic                   o_aluSrc,
  output logic [1:0]             o_aluOp,
  output logic                   o_link
);

  localparam int NREGS = 2**NB_REG_ADDR;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_XOR = 6'h26, FN_SLT = 6'h2A;

  typedef struct packed {
    logic                   valid;
    logic [NB_REG_ADDR-1:0] rs;
    logic [NB_REG_ADDR-1:0] rt;
    logic [NB_REG_ADDR-1:0] wr_addr;
    logic [NB_DATA-1:0]     da;
    logic [NB_DATA-1:0]     db;
    logic [NB_DATA-1:0]     imm;
    logic [NB_DATA-1:0]     pc4;
    logic [5:0]             opcode;
    logic [4:0]             shamt;
    logic [5:0]             func;
    logic                   regWrite;
    logic                   mem2Reg;
    logic                   memRead;
    logic                   memWrite;
    logic                   aluSrc;
    logic [1:0]             aluOp;
    logic                   link;
  } idex_t;

  logic [NB_DATA-1:0] r_regs [NREGS];
  idex_t              r_idex;
  idex_t              w_dec;

  // ---- instruction fields
  logic [5:0]             w_op, w_fn;
  logic [4:0]             w_shamt;
  logic [15:0]            w_imm16;
  logic [25:0]            w_imm26;
  logic [NB_REG_ADDR-1:0] w_rs, w_rt, w_rd;

  assign w_op    = i_instruction[31:26];
  assign w_fn    = i_instruction[5:0];
  assign w_shamt = i_instruction[10:6];
  assign w_imm16 = i_instruction[15:0];
  assign w_imm26 = i_instruction[25:0];
  assign w_rs    = NB_REG_ADDR'(i_instruction[25:21]);
  assign w_rt    = NB_REG_ADDR'(i_instruction[20:16]);
  assign w_rd    = NB_REG_ADDR'(i_instruction[15:11]);

  logic [NB_DATA-1:0] w_sext, w_zext, w_jext, w_br_tgt, w_j_tgt;
  assign w_sext   = {{(NB_DATA-16){w_imm16[15]}}, w_imm16};
  assign w_zext   = NB_DATA'(w_imm16);
  assign w_jext   = NB_DATA'(w_imm26);
  assign w_br_tgt = i_pcounter4 + {w_sext[NB_DATA-3:0], 2'b00};
  assign w_j_tgt  = {i_pcounter4[NB_DATA-1:28], w_imm26, 2'b00};

  // ---- register file: reg 0 is never written, so it always reads 0
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_wb_we && i_wb_addr != '0) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  logic [NB_DATA-1:0] w_rd_a, w_rd_b;
  assign w_rd_a = (w_rs == '0) ? '0 :
                  (i_wb_we && i_wb_addr == w_rs) ? i_wb_data : r_regs[w_rs];
  assign w_rd_b = (w_rt == '0) ? '0 :
                  (i_wb_we && i_wb_addr == w_rt) ? i_wb_data : r_regs[w_rt];

  // ---- main decoder
  logic w_known, w_use_rs, w_use_rt, w_is_br, w_is_jr, w_is_j;

  always_comb begin
    w_dec          = '0;
    w_known        = 1'b0;
    w_use_rs       = 1'b1;
    w_use_rt       = 1'b0;
    w_is_br        = 1'b0;
    w_is_jr        = 1'b0;
    w_is_j         = 1'b0;
    w_dec.valid    = 1'b1;
    w_dec.rs       = w_rs;
    w_dec.rt       = w_rt;
    w_dec.wr_addr  = w_rt;
    w_dec.da       = w_rd_a;
    w_dec.db       = w_rd_b;
    w_dec.imm      = w_sext;
    w_dec.pc4      = i_pcounter4;
    w_dec.opcode   = w_op;
    w_dec.shamt    = w_shamt;
    w_dec.func     = w_fn;
    case (w_op)
      OP_RTYPE: begin
        w_dec.wr_addr = w_rd;
        w_dec.aluOp   = 2'b10;
        w_use_rt      = 1'b1;
        case (w_fn)
          FN_JR: begin
            w_known = 1'b1;
            w_is_jr = 1'b1;
          end
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLL, FN_SRL: begin
            w_known        = 1'b1;
            w_dec.regWrite = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_known        = 1'b1;
        w_dec.regWrite = 1'b1;
        w_dec.aluSrc   = 1'b1;
        w_dec.aluOp    = 2'b11;
        // logical ops and LUI take the raw 16 bits; EX does the LUI shift
        if (w_op == OP_ANDI || w_op == OP_ORI || w_op == OP_XORI || w_op == OP_LUI)
          w_dec.imm = w_zext;
        if (w_op == OP_LUI) w_use_rs = 1'b0;
      end
      OP_LW: begin
        w_known        = 1'b1;
        w_dec.regWrite = 1'b1;
        w_dec.mem2Reg  = 1'b1;
        w_dec.memRead  = 1'b1;
        w_dec.aluSrc   = 1'b1;
      end
      OP_SW: begin
        w_known        = 1'b1;
        w_use_rt       = 1'b1;
        w_dec.memWrite = 1'b1;
        w_dec.aluSrc   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_known     = 1'b1;
        w_use_rt    = 1'b1;
        w_is_br     = 1'b1;
        w_dec.aluOp = 2'b01;
      end
      OP_J, OP_JAL: begin
        w_known       = 1'b1;
        w_use_rs      = 1'b0;
        w_is_j        = 1'b1;
        w_dec.imm     = w_jext;
        w_dec.wr_addr = '0;
        if (w_op == OP_JAL) begin
          // EX passes DA straight through as the link value
          w_dec.wr_addr  = NB_REG_ADDR'(LINK_REG);
          w_dec.regWrite = 1'b1;
          w_dec.link     = 1'b1;
          w_dec.da       = i_pcounter4;
        end
      end
      default: ;
    endcase
  end

  // ---- hazards
  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  assign w_ex_rs  = (i_ex_wr_addr  != '0) && (i_ex_wr_addr  == w_rs);
  assign w_ex_rt  = (i_ex_wr_addr  != '0) && (i_ex_wr_addr  == w_rt);
  assign w_mem_rs = (i_mem_wr_addr != '0) && (i_mem_wr_addr == w_rs);
  assign w_mem_rt = (i_mem_wr_addr != '0) && (i_mem_wr_addr == w_rt);

  logic w_load_use, w_br_hz;
  assign w_load_use = i_ex_memRead && ((w_use_rs && w_ex_rs) || (w_use_rt && w_ex_rt));
  // Branch operands are compared in ID, so anything still in EX, or a load
  // in MEM, cannot be forwarded yet.
  assign w_br_hz = ((w_is_br || w_is_jr) &&
                    ((i_ex_regWrite && w_ex_rs) || (i_mem_memRead && w_mem_rs))) ||
                   (w_is_br &&
                    ((i_ex_regWrite && w_ex_rt) || (i_mem_memRead && w_mem_rt)));

  // Only a real, decodable instruction can hold the front end.
  assign o_stall = !i_rst && i_valid && w_known && (w_load_use || w_br_hz);

  // ---- early branch resolution with MEM-stage forwarding
  logic [NB_DATA-1:0] w_fwd_a, w_fwd_b;
  logic               w_take;
  assign w_fwd_a = (i_mem_regWrite && w_mem_rs) ? i_mem_alu_result : w_rd_a;
  assign w_fwd_b = (i_mem_regWrite && w_mem_rt) ? i_mem_alu_result : w_rd_b;
  assign w_take  = w_is_j || w_is_jr ||
                   (w_is_br && ((w_fwd_a == w_fwd_b) ^ (w_op == OP_BNE)));

  assign o_pc_sel    = !i_rst && i_valid && !o_stall && !i_flush && w_take;
  assign o_pc_target = w_is_jr ? w_fwd_a : (w_is_j ? w_j_tgt : w_br_tgt);
  assign o_illegal   = !i_rst && i_valid && !w_known;

  // ---- ID/EX register
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                                              r_idex <= '0;
    else if (i_flush || o_stall || !i_valid || !w_known)    r_idex <= '0;
    else                                                    r_idex <= w_dec;
  end

  assign o_valid     = r_idex.valid;
  assign o_rs        = r_idex.rs;
  assign o_rt        = r_idex.rt;
  assign o_wr_addr   = r_idex.wr_addr;
  assign o_reg_DA    = r_idex.da;
  assign o_reg_DB    = r_idex.db;
  assign o_immediate = r_idex.imm;
  assign o_pcounter4 = r_idex.pc4;
  assign o_opcode    = r_idex.opcode;
  assign o_shamt     = r_idex.shamt;
  assign o_func      = r_idex.func;
  assign o_regWrite  = r_idex.regWrite;
  assign o_mem2Reg   = r_idex.mem2Reg;
  assign o_memRead   = r_idex.memRead;
  assign o_memWrite  = r_idex.memWrite;
  assign o_aluSrc    = r_idex.aluSrc;
  assign o_aluOp     = r_idex.aluOp;
  assign o_link      = r_idex.link;

endmodule

// File: tb/tb_instruction_decode_hz.sv
module tb_instruction_decode_hz;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_instruction, i_pcounter4;
  logic        i_valid, i_flush, i_wb_we;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_ex_regWrite, i_ex_memRead;
  logic [4:0]  i_ex_wr_addr;
  logic        i_mem_regWrite, i_mem_memRead;
  logic [4:0]  i_mem_wr_addr;
  logic [31:0] i_mem_alu_result;
  logic        o_stall, o_pc_sel, o_illegal, o_valid;
  logic [31:0] o_pc_target;
  logic [4:0]  o_rs, o_rt, o_wr_addr, o_shamt;
  logic [31:0] o_reg_DA, o_reg_DB, o_immediate, o_pcounter4;
  logic [5:0]  o_opcode, o_func;
  logic        o_regWrite, o_mem2Reg, o_memRead, o_memWrite, o_aluSrc, o_link;
  logic [1:0]  o_aluOp;

  always #5 clk = ~clk;

  instruction_decode_hz #(.NB_DATA(32), .NB_REG_ADDR(5), .LINK_REG(31)) u_dut (
    .clk(clk), .i_rst(i_rst), .i_instruction(i_instruction), .i_pcounter4(i_pcounter4),
    .i_valid(i_valid), .i_flush(i_flush), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
    .i_wb_data(i_wb_data), .i_ex_regWrite(i_ex_regWrite), .i_ex_memRead(i_ex_memRead),
    .i_ex_wr_addr(i_ex_wr_addr), .i_mem_regWrite(i_mem_regWrite), .i_mem_memRead(i_mem_memRead),
    .i_mem_wr_addr(i_mem_wr_addr), .i_mem_alu_result(i_mem_alu_result),
    .o_stall(o_stall), .o_pc_sel(o_pc_sel), .o_pc_target(o_pc_target), .o_illegal(o_illegal),
    .o_valid(o_valid), .o_rs(o_rs), .o_rt(o_rt), .o_wr_addr(o_wr_addr), .o_reg_DA(o_reg_DA),
    .o_reg_DB(o_reg_DB), .o_immediate(o_immediate), .o_pcounter4(o_pcounter4),
    .o_opcode(o_opcode), .o_shamt(o_shamt), .o_func(o_func), .o_regWrite(o_regWrite),
    .o_mem2Reg(o_mem2Reg), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
    .o_aluSrc(o_aluSrc), .o_aluOp(o_aluOp), .o_link(o_link)
  );

  typedef enum {K_RALU, K_JR, K_IALU_S, K_IALU_Z, K_LUI, K_LW, K_SW,
                K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, wr;
    logic [31:0] da, db, imm, pc4;
    logic [5:0]  op;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic        rw, m2r, mr, mw, asrc;
    logic [1:0]  aop;
    logic        link;
  } exp_t;

  logic [31:0] mregs [32];
  int n_chk = 0, n_fail = 0;

  logic [5:0] ops_tab [16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                                6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] fn_tab  [10] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02,
                                6'h08, 6'h3F};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic kind_e kind_of(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: case (ins[5:0])
               6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02: return K_RALU;
               6'h08:   return K_JR;
               default: return K_ILL;
             endcase
      6'h08, 6'h09, 6'h0A: return K_IALU_S;
      6'h0C, 6'h0D, 6'h0E: return K_IALU_Z;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // architectural read as seen in ID: written value bypasses the file
  function automatic logic [31:0] rv(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (i_wb_we && i_wb_addr == a) return i_wb_data;
    return mregs[a];
  endfunction

  function automatic logic busy(input logic [4:0] r);
    return r != 5'd0 && ((i_ex_regWrite && i_ex_wr_addr == r) ||
                         (i_mem_memRead && i_mem_wr_addr == r));
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r != 5'd0 && i_mem_regWrite && i_mem_wr_addr == r) return i_mem_alu_result;
    return rv(r);
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [31:0] ins;
    ins = $urandom;
    ins[31:26] = ops_tab[$urandom_range(0, 15)];
    if ($urandom_range(0, 19) == 0) ins[31:26] = ($urandom_range(0, 1) != 0) ? 6'h3F : 6'h01;
    ins[25:21] = 5'($urandom_range(0, 7));
    ins[20:16] = 5'($urandom_range(0, 7));
    if (ins[31:26] == 6'h00) begin
      ins[15:11] = 5'($urandom_range(0, 7));
      ins[5:0]   = fn_tab[$urandom_range(0, 9)];
    end
    return ins;
  endfunction

  // One cycle: inputs already driven just after a falling edge.
  task automatic step();
    kind_e       k;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, tgt, off;
    logic        rs_used, rt_used, lu, hz, take, e_stall, e_sel, e_ill;
    exp_t        e;
    #1;
    if (i_rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      chk("rst_imm_valid", 32'(o_valid), 32'd0);
      chk("rst_imm_DA", o_reg_DA, 32'd0);
      chk("rst_imm_rw", 32'(o_regWrite), 32'd0);
    end
    k  = kind_of(i_instruction);
    rs = i_instruction[25:21];
    rt = i_instruction[20:16];
    rd = i_instruction[15:11];
    rs_used = !(k inside {K_J, K_JAL, K_LUI, K_ILL});
    rt_used = k inside {K_RALU, K_JR, K_SW, K_BEQ, K_BNE};
    lu = i_ex_memRead && i_ex_wr_addr != 5'd0 &&
         ((rs_used && i_ex_wr_addr == rs) || (rt_used && i_ex_wr_addr == rt));
    hz = 1'b0;
    if (k inside {K_BEQ, K_BNE, K_JR}) hz = hz | busy(rs);
    if (k inside {K_BEQ, K_BNE})       hz = hz | busy(rt);
    a   = opnd(rs);
    b   = opnd(rt);
    off = int'($signed(i_instruction[15:0])) * 4;
    take = 1'b0;
    tgt  = 32'd0;
    case (k)
      K_BEQ:      begin take = (a == b); tgt = i_pcounter4 + off; end
      K_BNE:      begin take = (a != b); tgt = i_pcounter4 + off; end
      K_J, K_JAL: begin take = 1'b1;
                        tgt = (i_pcounter4 & 32'hF000_0000) | (32'(i_instruction[25:0]) * 4); end
      K_JR:       begin take = 1'b1; tgt = a; end
      default: ;
    endcase
    e_stall = !i_rst && i_valid && k != K_ILL && (lu || hz);
    e_sel   = !i_rst && i_valid && !e_stall && !i_flush && take;
    e_ill   = !i_rst && i_valid && k == K_ILL;
    chk("stall", 32'(o_stall), 32'(e_stall));
    chk("pc_sel", 32'(o_pc_sel), 32'(e_sel));
    if (e_sel) chk("pc_target", o_pc_target, tgt);
    chk("illegal", 32'(o_illegal), 32'(e_ill));

    e = '0;
    if (!(i_rst || i_flush || e_stall || !i_valid || k == K_ILL)) begin
      e.valid = 1'b1;
      e.rs  = rs;
      e.rt  = rt;
      e.pc4 = i_pcounter4;
      e.op  = i_instruction[31:26];
      e.sh  = i_instruction[10:6];
      e.fn  = i_instruction[5:0];
      e.da  = (k == K_JAL) ? i_pcounter4 : rv(rs);
      e.db  = rv(rt);
      case (k)
        K_RALU, K_JR: e.wr = rd;
        K_JAL:        e.wr = 5'd31;
        K_J:          e.wr = 5'd0;
        default:      e.wr = rt;
      endcase
      if (k inside {K_IALU_Z, K_LUI})  e.imm = {16'h0, i_instruction[15:0]};
      else if (k inside {K_J, K_JAL})  e.imm = {6'h0, i_instruction[25:0]};
      else                             e.imm = int'($signed(i_instruction[15:0]));
      e.rw   = k inside {K_RALU, K_IALU_S, K_IALU_Z, K_LUI, K_LW, K_JAL};
      e.m2r  = (k == K_LW);
      e.mr   = (k == K_LW);
      e.mw   = (k == K_SW);
      e.asrc = k inside {K_IALU_S, K_IALU_Z, K_LUI, K_LW, K_SW};
      if (k inside {K_BEQ, K_BNE})                         e.aop = 2'd1;
      else if (k inside {K_RALU, K_JR})                    e.aop = 2'd2;
      else if (k inside {K_IALU_S, K_IALU_Z, K_LUI})       e.aop = 2'd3;
      else                                                 e.aop = 2'd0;
      e.link = (k == K_JAL);
    end

    @(posedge clk);
    if (!i_rst && i_wb_we && i_wb_addr != 5'd0) mregs[i_wb_addr] = i_wb_data;
    #1;
    chk("valid", 32'(o_valid), 32'(e.valid));
    chk("rs", 32'(o_rs), 32'(e.rs));
    chk("rt", 32'(o_rt), 32'(e.rt));
    chk("wr_addr", 32'(o_wr_addr), 32'(e.wr));
    chk("DA", o_reg_DA, e.da);
    chk("DB", o_reg_DB, e.db);
    chk("imm", o_immediate, e.imm);
    chk("pc4", o_pcounter4, e.pc4);
    chk("opcode", 32'(o_opcode), 32'(e.op));
    chk("shamt", 32'(o_shamt), 32'(e.sh));
    chk("func", 32'(o_func), 32'(e.fn));
    chk("regWrite", 32'(o_regWrite), 32'(e.rw));
    chk("mem2Reg", 32'(o_mem2Reg), 32'(e.m2r));
    chk("memRead", 32'(o_memRead), 32'(e.mr));
    chk("memWrite", 32'(o_memWrite), 32'(e.mw));
    chk("aluSrc", 32'(o_aluSrc), 32'(e.asrc));
    chk("aluOp", 32'(o_aluOp), 32'(e.aop));
    chk("link", 32'(o_link), 32'(e.link));
  endtask

  task automatic quiet();
    i_flush = 1'b0; i_wb_we = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'd0;
    i_ex_regWrite = 1'b0; i_ex_memRead = 1'b0; i_ex_wr_addr = 5'd0;
    i_mem_regWrite = 1'b0; i_mem_memRead = 1'b0; i_mem_wr_addr = 5'd0;
    i_mem_alu_result = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    quiet();
    i_rst = 1'b1; i_valid = 1'b0; i_instruction = 32'd0; i_pcounter4 = 32'd0;
    @(negedge clk); step();
    @(negedge clk); i_rst = 1'b0; step();

    // $1 = 5, $2 = 7, then ADDU $3,$1,$2
    @(negedge clk); i_wb_we = 1'b1; i_wb_addr = 5'd1; i_wb_data = 32'd5; step();
    @(negedge clk); i_wb_addr = 5'd2; i_wb_data = 32'd7; step();
    @(negedge clk); i_wb_we = 1'b0; i_valid = 1'b1; i_pcounter4 = 32'h10;
    i_instruction = rtype(5'd1, 5'd2, 5'd3, 6'h21); step();
    chk("addu_DA", o_reg_DA, 32'd5);
    chk("addu_DB", o_reg_DB, 32'd7);
    chk("addu_wr", 32'(o_wr_addr), 32'd3);
    chk("addu_rw", 32'(o_regWrite), 32'd1);
    chk("addu_aop", 32'(o_aluOp), 32'd2);

    // same-cycle WB bypass, and writes to $0 are dropped
    @(negedge clk); i_wb_we = 1'b1; i_wb_addr = 5'd1; i_wb_data = 32'hDEADBEEF;
    i_instruction = rtype(5'd1, 5'd0, 5'd4, 6'h21); step();
    chk("bypass_DA", o_reg_DA, 32'hDEADBEEF);
    @(negedge clk); i_wb_addr = 5'd0; i_wb_data = 32'h1234;
    i_instruction = rtype(5'd0, 5'd1, 5'd4, 6'h21); step();
    @(negedge clk); i_wb_we = 1'b0; step();
    chk("r0_zero", o_reg_DA, 32'd0);

    // load-use stall then resume
    @(negedge clk); i_ex_memRead = 1'b1; i_ex_regWrite = 1'b1; i_ex_wr_addr = 5'd2;
    i_instruction = rtype(5'd1, 5'd2, 5'd3, 6'h21); step();
    chk("lu_bubble", 32'(o_valid), 32'd0);
    @(negedge clk); quiet(); step();
    chk("lu_resume", 32'(o_valid), 32'd1);

    // BEQ taken; BNE with MEM-forwarded equal operand not taken
    @(negedge clk); i_pcounter4 = 32'h100; i_instruction = itype(6'h04, 5'd1, 5'd1, 16'd4);
    #1; chk("beq_sel", 32'(o_pc_sel), 32'd1); chk("beq_tgt", o_pc_target, 32'h110); step();
    @(negedge clk); i_instruction = itype(6'h05, 5'd1, 5'd2, 16'd4);
    i_mem_regWrite = 1'b1; i_mem_wr_addr = 5'd2; i_mem_alu_result = 32'hDEADBEEF;
    #1; chk("bne_fwd_sel", 32'(o_pc_sel), 32'd0); step();

    // J, JAL, illegal opcode
    @(negedge clk); quiet(); i_pcounter4 = 32'h8; i_instruction = {6'h02, 26'd16};
    #1; chk("j_sel", 32'(o_pc_sel), 32'd1); chk("j_tgt", o_pc_target, 32'h40); step();
    @(negedge clk); i_instruction = {6'h03, 26'd16}; step();
    chk("jal_wr", 32'(o_wr_addr), 32'd31);
    chk("jal_DA", o_reg_DA, 32'h8);
    chk("jal_link", 32'(o_link), 32'd1);
    @(negedge clk); i_instruction = {6'h3F, 26'd0};
    #1; chk("ill_flag", 32'(o_illegal), 32'd1); step();
    chk("ill_bubble", 32'(o_valid), 32'd0);

    // reset in the middle of a stall, then $5 reads 0
    @(negedge clk); i_ex_memRead = 1'b1; i_ex_wr_addr = 5'd2;
    i_instruction = rtype(5'd1, 5'd2, 5'd3, 6'h21); step();
    @(negedge clk); i_rst = 1'b1; #1; chk("rst_stall_drop", 32'(o_stall), 32'd0); step();
    @(negedge clk); i_rst = 1'b0; quiet(); i_instruction = rtype(5'd5, 5'd0, 5'd6, 6'h21); step();
    chk("rst_r5", o_reg_DA, 32'd0);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      i_rst            = ($urandom_range(0, 99) == 0);
      i_instruction    = rnd_ins();
      i_pcounter4      = $urandom & 32'hFFFF_FFFC;
      i_valid          = ($urandom_range(0, 9) != 0);
      i_flush          = ($urandom_range(0, 9) == 0);
      i_wb_we          = ($urandom_range(0, 1) != 0);
      i_wb_addr        = 5'($urandom_range(0, 7));
      i_wb_data        = $urandom;
      i_ex_regWrite    = ($urandom_range(0, 2) == 0);
      i_ex_memRead     = ($urandom_range(0, 4) == 0);
      i_ex_wr_addr     = 5'($urandom_range(0, 7));
      i_mem_regWrite   = ($urandom_range(0, 2) == 0);
      i_mem_memRead    = ($urandom_range(0, 5) == 0);
      i_mem_wr_addr    = 5'($urandom_range(0, 7));
      i_mem_alu_result = ($urandom_range(0, 1) != 0) ? mregs[$urandom_range(0, 7)] : $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
